sha256_digest_reader: RTL and testbench
=======================================

# sha256_digest_reader

Readout end of the SHA-256 core's digest path. Captures the final 256-bit hash state (H0..H7) in one cycle on a load strobe. Streams it out as eight 32-bit words over a valid/ready handshake, H0 first, with a last-word flag and a completion pulse. Sits between the hash-state registers and the host/bus interface, so the core can start the next message while the previous digest drains.

## Interface
- WORD_W, 32, width of each output word
- NUM_WORDS, 8, number of words per digest; digest width = WORD_W*NUM_WORDS
- CLK  input  1  clock, all state changes on rising edge
- RST  input  1  asynchronous, active-low reset (RST=0 clears all state immediately)
- load  input  1  capture digest_i and begin streaming; honoured only in IDLE
- digest_i  input  WORD_W*NUM_WORDS  digest; H0 = digest_i[255:224], H7 = digest_i[31:0]
- ready_i  input  1  downstream can accept word_o this cycle
- word_o  output  WORD_W  current output word
- valid_o  output  1  word_o is valid
- last_o  output  1  word_o is the final word (H7); only meaningful with valid_o
- busy_o  output  1  streaming in progress (state SEND)
- done_o  output  1  one-cycle pulse after the final handshake

## Operation
- Internal state: 256-bit shadow register, 3-bit word index idx (log2 NUM_WORDS), FSM {IDLE, SEND}.
- Reset values: state=IDLE, idx=0, shadow=0, word_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0.
- IDLE, load=1: shadow <= digest_i, idx <= 0, state -> SEND.
- IDLE, load=0: hold; valid_o=0.
- SEND: valid_o=1, busy_o=1, word_o = shadow word idx (idx 0 = H0), last_o = (idx==NUM_WORDS-1).
- Handshake = valid_o & ready_i at a rising edge.
- Handshake with idx<NUM_WORDS-1: idx <= idx+1.
- Handshake with idx==NUM_WORDS-1: state -> IDLE, idx <= 0, done_o=1 for the next cycle.
- No handshake: word_o, last_o and idx hold. valid_o never drops once raised until the handshake.
- load while in SEND is ignored; shadow is not overwritten. The producer must wait for busy_o=0.
- load in the cycle done_o is high is accepted, because state is already IDLE.
- digest_i changes after capture have no effect on the stream.
- RST low at any point, including mid-stream, aborts immediately and returns all outputs to reset values. No done_o is generated for the aborted digest.
- idx never wraps past NUM_WORDS-1; no out-of-range word is ever presented.

## Timing
- Load accepted at edge N: valid_o=1 with H0 from cycle N+1, so first-word latency is 1 cycle.
- With ready_i held high, H0..H7 appear in cycles N+1..N+8, one per cycle.
- last_o is high in cycle N+8.
- done_o is high in cycle N+9; busy_o is low from N+9.
- Each cycle with ready_i=0 during SEND adds exactly one cycle to the stream.
- Minimum load-to-load spacing is 9 cycles (8 words plus the IDLE cycle).
- All outputs are registered; no combinational path from ready_i or load to any output.

## Test plan
- Reset: hold RST=0 with load=1 and ready_i=1 -> all outputs 0; after release with load=0, valid_o stays 0.
- Load the "abc" digest ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad with ready_i=1 -> words in that order in cycles N+1..N+8, last_o only with f20015ad, done_o single pulse at N+9.
- Same digest with ready_i toggling 1,0,0,1,... -> word_o and last_o stable while ready_i=0, no word skipped or duplicated, done_o only after f20015ad is accepted.
- load pulsed at cycle N+3 with digest_i=all-ones during the stream -> ignored, stream unchanged; load asserted in the done_o cycle -> new digest H0 appears the next cycle.
- Drive digest_i to 0 one cycle after load -> stream still outputs the captured "abc" words.
- Assert RST=0 while word 4 (b00361a3) is presented -> valid_o, busy_o, last_o and word_o are 0 immediately; no done_o. After RST release, a fresh load streams from H0.

Source files
------------

// File: rtl/sha256_digest_reader.sv
// sha256_digest_reader
// Captures a finished SHA-256 hash state in one cycle and streams it out
// as NUM_WORDS words (H0 first) over a valid/ready handshake, so the hash
// core is free to start on the next message while this digest drains.
//
// Handshake: a word transfers at a rising edge where valid_o and ready_i
// are both high. Once valid_o rises, it stays high and word_o/last_o stay
// stable until that transfer. ready_i may change freely and never reaches
// an output combinationally. last_o marks the final word and is only
// meaningful while valid_o is high.
//
// All outputs are registered. Their next values are computed from the
// next state and next index.

module sha256_digest_reader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        load,
  input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
  input  logic                        ready_i,
  output logic [WORD_W-1:0]           word_o,
  output logic                        valid_o,
  output logic                        last_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        dbg_state_o
);

  localparam int DIGEST_W = WORD_W * NUM_WORDS;
  localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // State and datapath registers
  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [DIGEST_W-1:0]   r_shadow;

  // Registered outputs
  logic [WORD_W-1:0]     r_word;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;

  // Next-state and next-output values
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [DIGEST_W-1:0]   w_shadow_nxt;
  logic [WORD_W-1:0]     w_word_nxt;
  logic                  w_valid_nxt;
  logic                  w_last_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  // Event decodes
  logic                  w_hs;
  logic                  w_load_ok;
  logic                  w_final;

  // A transfer happens on valid & ready. A load is only taken in IDLE, so a
  // load during SEND never touches the shadow copy being streamed.
  assign w_hs      = r_valid & ready_i;
  assign w_load_ok = (r_state == S_IDLE) & load;
  assign w_final   = w_hs & (r_idx == LAST_IDX);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> SEND on an accepted load, and SEND -> IDLE on
  // the transfer of the last word
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_final) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Word index and shadow update. The index restarts at H0 on a load,
  // advances on each transfer, and returns to 0 after the last word, so it
  // never points past the final word.
  always_comb begin
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    if (w_load_ok) begin
      w_idx_nxt    = '0;
      w_shadow_nxt = digest_i;
    end else if (w_hs) begin
      if (r_idx == LAST_IDX) begin
        w_idx_nxt = '0;
      end else begin
        w_idx_nxt = r_idx + IDX_W'(1);
      end
    end
  end

  // Output decode from the next state. Word i is taken from the top of the
  // digest downward, so word 0 is H0 (the most significant 32 bits). The
  // word path uses w_shadow_nxt so that H0 is already present in the first
  // SEND cycle.
  always_comb begin
    w_valid_nxt = (w_state_nxt == S_SEND);
    w_busy_nxt  = (w_state_nxt == S_SEND);
    w_last_nxt  = (w_state_nxt == S_SEND) && (w_idx_nxt == LAST_IDX);
    w_done_nxt  = w_final;
    w_word_nxt  = '0;
    if (w_state_nxt == S_SEND) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (w_idx_nxt == IDX_W'(i)) begin
          w_word_nxt = w_shadow_nxt[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Datapath and output registers. Reset clears everything, so a digest
  // that is aborted part-way never produces done_o.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_idx    <= '0;
      r_shadow <= '0;
      r_word   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_word   <= w_word_nxt;
      r_valid  <= w_valid_nxt;
      r_last   <= w_last_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign word_o      = r_word;
  assign valid_o     = r_valid;
  assign last_o      = r_last;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Directed bench for sha256_digest_reader. It streams the "abc" and the
// empty-string SHA-256 digests and checks each word against tables built
// from the hand-written constants.

module tb_sha256_digest_reader;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;

  // clock / reset block
  logic                        CLK;
  logic                        RST;
  logic                        load;
  logic [WORD_W*NUM_WORDS-1:0] digest_i;
  logic                        ready_i;
  logic [WORD_W-1:0]           word_o;
  logic                        valid_o;
  logic                        last_o;
  logic                        busy_o;
  logic                        done_o;
  logic                        dbg_state_o;

  int n_vec  = 0;
  int n_fail = 0;

  logic [255:0] abc_d;
  logic [255:0] emp_d;
  logic [31:0]  abc_w [NUM_WORDS];
  logic [31:0]  emp_w [NUM_WORDS];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  sha256_digest_reader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .load        (load),
    .digest_i    (digest_i),
    .ready_i     (ready_i),
    .word_o      (word_o),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state_o)
  );

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Watchdog: the sequence is short, so this only fires if the bench hangs
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_idx;
    int cyc;
    logic rdy;

    abc_d = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    emp_d = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    for (int k = 0; k < NUM_WORDS; k++) begin
      abc_w[k] = abc_d[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
      emp_w[k] = emp_d[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
    end

    // Reset held with load and ready active: every output must stay 0
    RST      = 1'b0;
    load     = 1'b1;
    ready_i  = 1'b1;
    digest_i = abc_d;
    repeat (3) tick();
    chk("rst_word",  word_o,      32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_last",  {31'b0, last_o},  32'h0);
    chk("rst_busy",  {31'b0, busy_o},  32'h0);
    chk("rst_done",  {31'b0, done_o},  32'h0);
    chk("rst_state", {31'b0, dbg_state_o}, 32'h0);
    load = 1'b0;
    RST  = 1'b1;
    tick();
    tick();
    chk("idle_valid", {31'b0, valid_o}, 32'h0);
    chk("idle_busy",  {31'b0, busy_o},  32'h0);

    // "abc" stream with ready high. digest_i goes to 0 right after capture,
    // and an all-ones load pulse lands in cycle N+3; neither may affect it.
    load     = 1'b1;
    digest_i = abc_d;
    tick();
    load     = 1'b0;
    digest_i = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      chk("s1_word",  word_o, abc_w[k]);
      chk("s1_valid", {31'b0, valid_o}, 32'h1);
      chk("s1_busy",  {31'b0, busy_o},  32'h1);
      chk("s1_last",  {31'b0, last_o},  (k == NUM_WORDS-1) ? 32'h1 : 32'h0);
      chk("s1_done",  {31'b0, done_o},  32'h0);
      if (k == 2) begin
        load     = 1'b1;
        digest_i = '1;
      end else begin
        load     = 1'b0;
        digest_i = '0;
      end
      tick();
    end
    chk("s1_done_pulse", {31'b0, done_o},  32'h1);
    chk("s1_end_busy",   {31'b0, busy_o},  32'h0);
    chk("s1_end_valid",  {31'b0, valid_o}, 32'h0);

    // A load in the done_o cycle is accepted and H0 follows one cycle later
    load     = 1'b1;
    digest_i = emp_d;
    tick();
    load = 1'b0;
    chk("b2b_valid", {31'b0, valid_o}, 32'h1);
    chk("b2b_done",  {31'b0, done_o},  32'h0);
    for (int k = 0; k < NUM_WORDS; k++) begin
      chk("s2_word", word_o, emp_w[k]);
      chk("s2_last", {31'b0, last_o}, (k == NUM_WORDS-1) ? 32'h1 : 32'h0);
      tick();
    end
    chk("s2_done_pulse", {31'b0, done_o}, 32'h1);
    tick();
    chk("s2_done_single", {31'b0, done_o}, 32'h0);

    // "abc" again with ready toggling 1,0,0,1,0,0,...: words hold while
    // ready is low, and none is skipped or repeated
    load     = 1'b1;
    digest_i = abc_d;
    tick();
    load    = 1'b0;
    exp_idx = 0;
    cyc     = 0;
    while (exp_idx < NUM_WORDS && cyc < 60) begin
      chk("tg_word",  word_o, abc_w[exp_idx]);
      chk("tg_last",  {31'b0, last_o},  (exp_idx == NUM_WORDS-1) ? 32'h1 : 32'h0);
      chk("tg_valid", {31'b0, valid_o}, 32'h1);
      chk("tg_done",  {31'b0, done_o},  32'h0);
      rdy     = (cyc % 3 == 0);
      ready_i = rdy;
      tick();
      if (rdy) exp_idx++;
      cyc++;
    end
    chk("tg_complete", exp_idx, NUM_WORDS);
    chk("tg_done_pulse", {31'b0, done_o},  32'h1);
    chk("tg_end_valid",  {31'b0, valid_o}, 32'h0);
    ready_i = 1'b1;
    tick();
    chk("tg_done_single", {31'b0, done_o}, 32'h0);

    // Reset mid-stream while word 4 is presented: immediate abort, no done_o
    load     = 1'b1;
    digest_i = abc_d;
    tick();
    load = 1'b0;
    repeat (4) tick();
    chk("ab_word4", word_o, 32'hb00361a3);
    RST = 1'b0;
    #1;
    chk("ab_word",  word_o, 32'h0);
    chk("ab_valid", {31'b0, valid_o}, 32'h0);
    chk("ab_busy",  {31'b0, busy_o},  32'h0);
    chk("ab_last",  {31'b0, last_o},  32'h0);
    chk("ab_done",  {31'b0, done_o},  32'h0);
    tick();
    RST = 1'b1;
    tick();
    chk("ab_post_done",  {31'b0, done_o},  32'h0);
    chk("ab_post_valid", {31'b0, valid_o}, 32'h0);

    // A fresh load after the abort starts again from H0
    load     = 1'b1;
    digest_i = abc_d;
    tick();
    load = 1'b0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      chk("s4_word", word_o, abc_w[k]);
      chk("s4_last", {31'b0, last_o}, (k == NUM_WORDS-1) ? 32'h1 : 32'h0);
      tick();
    end
    chk("s4_done_pulse", {31'b0, done_o}, 32'h1);
    tick();
    chk("s4_done_single", {31'b0, done_o}, 32'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
